flag_sequencer: RTL and testbench
=================================

Name: flag_sequencer

Overview:
- Initiator-side controller for the flag counter: drives its EN input and consumes its S1/S2 flag outputs.
- On a Start pulse it opens an EN window and waits for S1 (first threshold), then S2 (terminal flag).
- It measures the S1→S2 gap in clock cycles and reports Done, Timeout or protocol Error.
- Sits between the control logic and one flag counter instance, on the counter's clock.

Parameters:
- CNT_W, 8, width of the gap measurement and watchdog counters.
- TIMEOUT_CYCLES, 200, maximum EN-high cycles before the watchdog fires; must be < 2^CNT_W.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request to begin a sequence; ignored unless Busy=0.
- Abort  in  1  synchronous abort; returns the block to IDLE.
- S1  in  1  counter first-threshold flag; synchronous to Clk, level.
- S2  in  1  counter terminal flag; synchronous to Clk, level.
- EN  out  1  counter enable; registered.
- Busy  out  1  high in any state except IDLE.
- Done  out  1  one-cycle pulse on successful completion.
- Timeout  out  1  one-cycle pulse when the watchdog expires.
- Error  out  1  one-cycle pulse when S2 rises before S1.
- Gap  out  CNT_W  cycles from the S1 rising edge to the S2 rising edge; holds until the next Gap_Valid.
- Gap_Valid  out  1  one-cycle pulse, coincident with Done.

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE; EN, Busy, Done, Timeout, Error, Gap_Valid = 0; Gap = 0; previous-flag registers (s1_q, s2_q) = 0; watchdog = 0.
- Edge detection:
  - s1_rise = S1 & ~s1_q; s2_rise = S2 & ~s2_q.
  - s1_q and s2_q update every cycle in every state.
- States: IDLE, WAIT_S1, WAIT_S2, DRAIN.
- IDLE:
  - Start=1 → WAIT_S1; EN=1 from the next cycle.
  - Watchdog and gap counter cleared.
  - If Start and Abort are both high, Abort wins: stay in IDLE.
- WAIT_S1 (EN=1):
  - Watchdog increments each cycle.
  - s1_rise & ~s2_rise → WAIT_S2; gap counter = 0.
  - s1_rise & s2_rise (simultaneous) → DRAIN; gap = 0.
  - s2_rise without s1_rise → IDLE; Error pulse; EN drops next cycle.
- WAIT_S2 (EN=1):
  - Watchdog and gap counter increment each cycle; gap counter saturates at 2^CNT_W−1.
  - s2_rise → DRAIN; Gap ← gap counter + 1.
- DRAIN:
  - EN=0; lasts exactly one cycle.
  - Then → IDLE with Done=1 and Gap_Valid=1 in the IDLE-entry cycle.
- Watchdog: when the count reaches TIMEOUT_CYCLES in WAIT_S1 or WAIT_S2 → IDLE; Timeout pulse; EN=0 next cycle; Gap unchanged.
- Abort: in any non-IDLE state → IDLE next cycle; EN=0; no Done, Timeout or Error pulse. Abort has priority over flag edges and the watchdog.
- Priority within one cycle: Abort > s2_rise/s1_rise handling > watchdog expiry.
- Start while Busy=1 is ignored (not queued).
- Flags already high when Start arrives produce no edge; the sequence then waits for a fresh rise or the watchdog.
- Latency: Start → EN=1 is 1 cycle; s2_rise → EN=0 is 1 cycle; s2_rise → Done is 2 cycles.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, WAIT_S1, WAIT_S2, DRAIN), 2-bit encoding;
  - the default CNT_W and TIMEOUT_CYCLES constants.
- One natural sub-module: flag_edge_detect (per-flag register plus rise output), instantiated twice.

Test Plan:
- Reset=0 at time 0 and released after 3 cycles; drive Start → all outputs 0 during reset; EN=1 on the cycle after Start.
- S1 rises 5 cycles after EN, S2 rises 12 cycles after S1 → Gap=12, Done and Gap_Valid pulse together 2 cycles after S2 rise, EN=0 one cycle after S2 rise.
- S1 and S2 rise in the same cycle → Gap=0, Done pulses, no Error.
- S2 rises with S1 still low → Error pulse, EN=0 next cycle, Gap holds its previous value, no Done.
- No flags for 200 cycles with TIMEOUT_CYCLES=200 → Timeout pulse exactly once, Busy=0 afterward.
- Abort in WAIT_S2, plus Reset asserted mid-WAIT_S1 in a separate run → IDLE, EN=0, no pulses, and a second Start runs a clean sequence.

Source files
------------

// File: rtl/flag_sequencer_pkg.sv
// Shared types and defaults for the flag counter sequencer.
package flag_sequencer_pkg;

  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned TIMEOUT_DEF = 200;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_S1 = 2'd1,
    ST_WAIT_S2 = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

endpackage

// File: rtl/flag_sequencer_if.sv
// Control/flag/status bundle between the control logic, the sequencer and the flag counter.
interface flag_sequencer_if
  import flag_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             start;
  logic             abort;
  logic             s1;
  logic             s2;
  logic             en;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             error;
  logic [CNT_W-1:0] gap;
  logic             gap_valid;

  modport master (
    output start, abort, s1, s2,
    input  en, busy, done, timeout, error, gap, gap_valid
  );

  modport slave (
    input  start, abort, s1, s2,
    output en, busy, done, timeout, error, gap, gap_valid
  );

endinterface

// File: rtl/flag_sequencer_edge.sv
// One flag's previous-value register and its rising-edge strobe.
module flag_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic flag,
  output logic rise_c
);

  logic flag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_q <= 1'b0;
    else        flag_q <= flag;
  end

  assign rise_c = flag & ~flag_q;

endmodule

// File: rtl/flag_sequencer.sv
// Opens an EN window on start, waits for S1 then S2, and reports the S1->S2 gap,
// a watchdog timeout, or an out-of-order S2 error.
module flag_sequencer
  import flag_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W          = CNT_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rst_n,
  flag_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state;
  logic [CNT_W-1:0] wd;
  logic [CNT_W-1:0] gcnt;
  logic             s1_rise_c;
  logic             s2_rise_c;
  logic             wd_expire_c;
  logic [CNT_W-1:0] gap_inc_c;

  flag_edge_detect u_s1 (.clk(clk), .rst_n(rst_n), .flag(bus.s1), .rise_c(s1_rise_c));
  flag_edge_detect u_s2 (.clk(clk), .rst_n(rst_n), .flag(bus.s2), .rise_c(s2_rise_c));

  // >= so an S1 taken on the last watchdog cycle still expires one cycle later in WAIT_S2
  assign wd_expire_c = (wd >= WD_LAST);
  assign gap_inc_c   = (gcnt == CNT_MAX) ? CNT_MAX : gcnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wd            <= '0;
      gcnt          <= '0;
      bus.en        <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.error     <= 1'b0;
      bus.gap       <= '0;
      bus.gap_valid <= 1'b0;
    end else begin
      bus.done      <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.error     <= 1'b0;
      bus.gap_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          wd   <= '0;
          gcnt <= '0;
          if (bus.start && !bus.abort) begin
            state    <= ST_WAIT_S1;
            bus.en   <= 1'b1;
            bus.busy <= 1'b1;
          end
        end
        ST_WAIT_S1: begin
          wd <= wd + CNT_W'(1);
          if (bus.abort || (s2_rise_c && !s1_rise_c) || (!s1_rise_c && wd_expire_c)) begin
            state       <= ST_IDLE;
            bus.en      <= 1'b0;
            bus.busy    <= 1'b0;
            bus.error   <= !bus.abort && s2_rise_c;
            bus.timeout <= !bus.abort && !s2_rise_c;
          end else if (s1_rise_c && s2_rise_c) begin
            state   <= ST_DRAIN;
            bus.en  <= 1'b0;
            bus.gap <= '0;
          end else if (s1_rise_c) begin
            state <= ST_WAIT_S2;
            gcnt  <= '0;
          end
        end
        ST_WAIT_S2: begin
          wd   <= wd + CNT_W'(1);
          gcnt <= gap_inc_c;
          if (bus.abort || (!s2_rise_c && wd_expire_c)) begin
            state       <= ST_IDLE;
            bus.en      <= 1'b0;
            bus.busy    <= 1'b0;
            bus.timeout <= !bus.abort;
          end else if (s2_rise_c) begin
            state   <= ST_DRAIN;
            bus.en  <= 1'b0;
            bus.gap <= gap_inc_c;
          end
        end
        ST_DRAIN: begin
          state         <= ST_IDLE;
          bus.busy      <= 1'b0;
          bus.done      <= !bus.abort;
          bus.gap_valid <= !bus.abort;
        end
        default: begin
          state    <= ST_IDLE;
          bus.en   <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_sequencer.sv
// Randomized sequences against a timeline model of the sequencer's EN window and result pulses.
module tb_flag_sequencer;
  import flag_sequencer_pkg::*;

  localparam int unsigned CW = 8;
  localparam int          TO = 200;
  localparam int M_NORM = 0, M_SIM = 1, M_ERR = 2, M_TO = 3, M_ABT = 4, M_PRE = 5, M_TO_S1 = 6;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_gap = 0;

  flag_sequencer_if #(.CNT_W(CW)) bus ();

  flag_sequencer #(.CNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {en, busy, done, timeout, error, gap_valid}
  function automatic logic [5:0] outs();
    return {bus.en, bus.busy, bus.done, bus.timeout, bus.error, bus.gap_valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step k drives inputs sampled at the k-th edge after the start edge. The window closes at
  // step 'close'; a successful run spends one extra cycle in drain and reports at close+1.
  task automatic run_seq(input int mode, input int t1, input int g, input int ta, input int st_seed);
    int         close, egap, last_k, st;
    bit         drain, to, err;
    logic [5:0] exp;
    bus.s1 = (mode == M_PRE);
    bus.s2 = 1'b0;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    tick();
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check($sformatf("start m%0d", mode), 32'(outs()), 32'(6'b110000));
    drain = 1'b0; to = 1'b0; err = 1'b0; egap = 0;
    case (mode)
      M_SIM:           begin close = t1; drain = 1'b1; egap = 0; end
      M_ERR, M_PRE:    begin close = t1; err = 1'b1; end
      M_TO, M_TO_S1:   begin close = TO; to = 1'b1; end
      M_ABT:           close = ta;
      default:         begin close = t1 + g; drain = 1'b1; egap = g; end
    endcase
    st = 1 + (st_seed % close);
    last_k = close + g + 3;
    for (int k = 1; k <= last_k; k++) begin
      case (mode)
        M_SIM, M_ERR: begin bus.s1 = (mode == M_SIM) && k >= t1; bus.s2 = (k >= t1); end
        M_PRE:        begin bus.s1 = 1'b1; bus.s2 = (k >= t1); end
        M_TO:         begin bus.s1 = 1'b0; bus.s2 = 1'b0; end
        M_TO_S1:      begin bus.s1 = (k >= t1); bus.s2 = 1'b0; end
        default:      begin bus.s1 = (k >= t1); bus.s2 = (k >= t1 + g); end
      endcase
      bus.abort = (mode == M_ABT) && (k == ta);
      bus.start = (k == st);
      tick();
      exp = {k < close, k < close + int'(drain), drain && k == close + 1,
             to && k == close, err && k == close, drain && k == close + 1};
      check($sformatf("outs m%0d k%0d", mode, k), 32'(outs()), 32'(exp));
      check($sformatf("gap m%0d k%0d", mode, k), 32'(bus.gap),
            32'((drain && k >= close) ? egap : last_gap));
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    if (drain) last_gap = egap;
  endtask

  initial begin
    int mode, t1, g, ta;
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.s1 = 1'b0;
    bus.s2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset outs", 32'(outs()), 32'd0);
      check("reset gap", 32'(bus.gap), 32'd0);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post reset", 32'(outs()), 32'd0);

    run_seq(M_NORM, 5, 12, 0, 7);
    run_seq(M_SIM, 4, 10, 0, 2);
    run_seq(M_ERR, 6, 10, 0, 3);
    run_seq(M_TO, 1, 5, 0, 50);
    run_seq(M_ABT, 3, 10, 8, 1);
    run_seq(M_NORM, 2, 9, 0, 4);

    // start together with abort in idle: abort wins
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start+abort idle", 32'(outs()), 32'd0);
    tick();
    check("start+abort after", 32'(outs()), 32'd0);

    // asynchronous reset in the middle of WAIT_S1
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("pre midreset", 32'(outs()), 32'(6'b110000));
    rst_n = 1'b0;
    #1;
    check("midreset outs", 32'(outs()), 32'd0);
    check("midreset gap", 32'(bus.gap), 32'd0);
    last_gap = 0;
    tick();
    rst_n = 1'b1;
    run_seq(M_NORM, 3, 6, 0, 2);

    for (int i = 0; i < 30; i++) begin
      mode = int'($urandom_range(0, 6));
      t1   = int'($urandom_range(1, 20));
      g    = int'($urandom_range(2, 40));
      ta   = int'($urandom_range(t1 + 1, t1 + g - 1));
      run_seq(mode, t1, g, ta, int'($urandom_range(0, 1000)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
